// File: rtl/prog_divide_fsm.sv
// Runtime-programmable divide-by-N tick and square-wave generator with start/stop control.
// Optional build macro PROG_DIVIDE_TICK_CNT_EN adds a 16-bit tick_cnt output.
module prog_divide_fsm #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic             tick,
  output logic             wave,
  output logic [WIDTH-1:0] phase,
  output logic             div_err,
  output logic             running
`ifdef PROG_DIVIDE_TICK_CNT_EN
  ,
  output logic [15:0]      tick_cnt
`endif
);

  // state | meaning
  // IDLE  | stopped; phase held at 0, pending divisor committed here
  // RUN   | counting phase 0..active_div-1; pending divisor committed at wrap

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             err_q, err_d;
  logic             load_ok;
  logic             wrap;
  logic [WIDTH:0]   high_len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      active_q   <= DIV_RST;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    load_ok    = div_load && (div_value != '0);
    err_d      = div_load && (div_value == '0);
    wrap       = (phase_q == (active_q - ONE));

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (load_ok) begin
          pend_d     = div_value;
          pend_vld_d = 1'b1;
        end else if (pend_vld_q) begin
          active_d   = pend_q;
          pend_vld_d = 1'b0;
        end
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          phase_d = '0;
          if (load_ok) begin
            pend_d     = div_value;
            pend_vld_d = 1'b1;
          end
        end else if (wrap) begin
          phase_d = '0;
          // A load landing on the wrap edge outranks any older pending value.
          if (load_ok) begin
            active_d   = div_value;
            pend_vld_d = 1'b0;
          end else if (pend_vld_q) begin
            active_d   = pend_q;
            pend_vld_d = 1'b0;
          end
        end else begin
          phase_d = phase_q + ONE;
          if (load_ok) begin
            pend_d     = div_value;
            pend_vld_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  // One extra bit so that ceil(N/2) stays correct at N = 2^WIDTH-1.
  assign high_len = ({1'b0, active_q} + (WIDTH + 1)'(1)) >> 1;

  assign running = (state_q == RUN);
  assign tick    = running && (phase_q == '0);
  assign wave    = running && ({1'b0, phase_q} < high_len);
  assign phase   = phase_q;
  assign div_err = err_q;

`ifdef PROG_DIVIDE_TICK_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= 16'd0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end
`endif

endmodule
